// File: rtl/switch_pkg.sv
// switch_pkg: widths and timing constants shared by the switch-conditioning blocks.
package switch_pkg;
    localparam int SWITCH_W = 8;
    localparam int MODE_W = 4;
    localparam int CFG_W = 4;
    localparam int CLK_HZ = 100_000;
    localparam int DEBOUNCE_100KHZ_20MS = CLK_HZ / 50;
endpackage

// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if: raw switch levels in, debounced levels and edge pulses out.
interface switch_debouncer_if import switch_pkg::*; #(
    parameter int WIDTH = SWITCH_W
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic [WIDTH-1:0] sw_toggle;
    logic sw_any_change;
    modport master (output sw_raw, input sw_stable, sw_rise, sw_fall, sw_any_change, sw_toggle);
    modport slave (input sw_raw, output sw_stable, sw_rise, sw_fall, sw_any_change, sw_toggle);
endinterface

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchronizer, persistence counter, stable level and edge pulses for one switch.
module debounce_bit import switch_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_100KHZ_20MS,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic accept
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic s1, s2;
    logic [CNT_W-1:0] cnt;
    // accept marks the edge at which the new level has persisted long enough
    assign accept = (s2 != stable) && (cnt == LAST);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            cnt <= '0;
            stable <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            rise <= accept && s2;
            fall <= accept && !s2;
            stable <= accept ? s2 : stable;
            cnt <= (s2 == stable || accept) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-bit debounce of a switch group with any-change flag.
// Optional toggle latches on each accepted rise when SWITCH_DEBOUNCER_TOGGLE_EN is defined.
module switch_debouncer import switch_pkg::*; #(
    parameter int WIDTH = SWITCH_W,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_100KHZ_20MS
) (
    input logic clk,
    input logic rstn,
    switch_debouncer_if.slave bus
);
    logic [WIDTH-1:0] accept;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
            .clk(clk),
            .rstn(rstn),
            .raw(bus.sw_raw[i]),
            .stable(bus.sw_stable[i]),
            .rise(bus.sw_rise[i]),
            .fall(bus.sw_fall[i]),
            .accept(accept[i])
        );
    end
    // registered from the accept strobes so it lines up with the rise/fall pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) bus.sw_any_change <= 1'b0;
        else bus.sw_any_change <= |accept;
    end
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) bus.sw_toggle <= '0;
        else bus.sw_toggle <= bus.sw_toggle ^ bus.sw_rise;
    end
`else
    assign bus.sw_toggle = '0;
`endif
endmodule
